// File: rtl/uart_mmio.sv
// rtl/uart_mmio.sv - memory-mapped 8N1 UART with TX FIFO, TX shifter, RX deserializer and status register
module uart_mmio #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          CLK_DIV   = 434,
    parameter int          TX_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] MemAddress,
    input  logic        MemWrite,
    input  logic [31:0] MemWriteData,
    output logic [31:0] ReadData,
    output logic        Hit,
    input  logic        uart_rxd,
    output logic        uart_txd
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int PW = $clog2(TX_DEPTH);
    localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
    localparam logic [PW:0]   DEPTH     = (PW + 1)'(TX_DEPTH);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    tx_state_t     tx_state;
    rx_state_t     rx_state;
    logic [7:0]    fifo [TX_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic [2:0]    tx_bit, rx_bit;
    logic [7:0]    tx_shift, rx_shift, rx_byte;
    logic          rx_sync1, rx_sync2;
    logic          rx_valid, rx_ovr, tx_ovf;

    logic [1:0] sel;
    logic       wr_en, tx_push, rx_clr, st_wr;
    logic       tx_full, fifo_empty, tx_pop, push_ok, tx_busy, rx_done;
    logic       unused_bits;

    assign Hit        = MemAddress[31:4] == BASE_ADDR[31:4];
    assign sel        = MemAddress[3:2];
    assign wr_en      = MemWrite & Hit;
    assign tx_push    = wr_en && sel == 2'd0;
    assign rx_clr     = wr_en && sel == 2'd1;
    assign st_wr      = wr_en && sel == 2'd2;
    assign tx_full    = count == DEPTH;
    assign fifo_empty = count == '0;
    // The shifter pulls the next byte either from idle or at the end of a stop bit.
    assign tx_pop     = !fifo_empty &&
                        (tx_state == TX_IDLE || (tx_state == TX_STOP && tx_cnt == '0));
    assign push_ok    = tx_push && (!tx_full || tx_pop);
    assign tx_busy    = tx_state != TX_IDLE || !fifo_empty;
    assign rx_done    = rx_state == RX_STOP && rx_cnt == '0 && rx_sync2;
    assign unused_bits = ^{MemWriteData[31:8], MemWriteData[2:0], MemAddress[1:0]};

    always_comb begin
        ReadData = '0;
        if (Hit) begin
            case (sel)
                2'd1:    ReadData = {24'b0, rx_byte};
                2'd2:    ReadData = {27'b0, tx_ovf, rx_ovr, tx_busy, tx_full, rx_valid};
                default: ReadData = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo[wr_ptr] <= MemWriteData[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (tx_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, tx_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            uart_txd <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    uart_txd <= 1'b1;
                    if (tx_pop) begin
                        tx_shift <= fifo[rd_ptr];
                        tx_state <= TX_START;
                        tx_cnt   <= DIV_LAST;
                        uart_txd <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tx_cnt != '0) tx_cnt <= tx_cnt - 1'b1;
                    else begin
                        tx_state <= TX_DATA;
                        tx_cnt   <= DIV_LAST;
                        tx_bit   <= '0;
                        uart_txd <= tx_shift[0];
                    end
                end
                TX_DATA: begin
                    if (tx_cnt != '0) tx_cnt <= tx_cnt - 1'b1;
                    else if (tx_bit == 3'd7) begin
                        tx_state <= TX_STOP;
                        tx_cnt   <= DIV_LAST;
                        uart_txd <= 1'b1;
                    end else begin
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        tx_bit   <= tx_bit + 1'b1;
                        tx_cnt   <= DIV_LAST;
                        uart_txd <= tx_shift[1];
                    end
                end
                TX_STOP: begin
                    if (tx_cnt != '0) tx_cnt <= tx_cnt - 1'b1;
                    else if (tx_pop) begin
                        tx_shift <= fifo[rd_ptr];
                        tx_state <= TX_START;
                        tx_cnt   <= DIV_LAST;
                        uart_txd <= 1'b0;
                    end else begin
                        tx_state <= TX_IDLE;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sync1 <= 1'b1;
            rx_sync2 <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_byte  <= '0;
        end else begin
            rx_sync1 <= uart_rxd;
            rx_sync2 <= rx_sync1;
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_sync2) begin
                        rx_state <= RX_START;
                        rx_cnt   <= HALF_LAST;
                    end
                end
                RX_START: begin
                    if (rx_cnt != '0) rx_cnt <= rx_cnt - 1'b1;
                    else if (rx_sync2) rx_state <= RX_IDLE;
                    else begin
                        rx_state <= RX_DATA;
                        rx_cnt   <= DIV_LAST;
                        rx_bit   <= '0;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt != '0) rx_cnt <= rx_cnt - 1'b1;
                    else begin
                        rx_shift <= {rx_sync2, rx_shift[7:1]};
                        rx_cnt   <= DIV_LAST;
                        rx_bit   <= rx_bit + 1'b1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt != '0) rx_cnt <= rx_cnt - 1'b1;
                    else begin
                        rx_state <= RX_IDLE;
                        if (rx_sync2) rx_byte <= rx_shift;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // Flag sets take priority over the CPU clears landing on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_valid <= 1'b0;
            rx_ovr   <= 1'b0;
            tx_ovf   <= 1'b0;
        end else begin
            if (rx_done)     rx_valid <= 1'b1;
            else if (rx_clr) rx_valid <= 1'b0;

            if (rx_done && rx_valid && !rx_clr) rx_ovr <= 1'b1;
            else if (st_wr && MemWriteData[3])  rx_ovr <= 1'b0;

            if (tx_push && tx_full && !tx_pop)  tx_ovf <= 1'b1;
            else if (st_wr && MemWriteData[4])  tx_ovf <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_mmio.sv
// tb/tb_uart_mmio.sv - self-checking bench for uart_mmio with a line-level UART reference model
module tb_uart_mmio;
    localparam logic [31:0] BASE   = 32'h4000_0000;
    localparam logic [31:0] A_TX   = BASE;
    localparam logic [31:0] A_RX   = BASE + 32'd4;
    localparam logic [31:0] A_ST   = BASE + 32'd8;
    localparam logic [31:0] A_RES  = BASE + 32'd12;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] MemAddress = '0;
    logic        MemWrite = 1'b0;
    logic [31:0] MemWriteData = '0;
    logic [31:0] ReadData;
    logic        Hit;
    logic        uart_rxd;
    logic        uart_txd;
    logic        loop = 1'b0;
    logic        rxd_drv = 1'b1;

    assign uart_rxd = loop ? uart_txd : rxd_drv;
    always #5 clk = ~clk;

    uart_mmio #(.BASE_ADDR(BASE), .CLK_DIV(4), .TX_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .MemAddress(MemAddress), .MemWrite(MemWrite),
        .MemWriteData(MemWriteData), .ReadData(ReadData), .Hit(Hit),
        .uart_rxd(uart_rxd), .uart_txd(uart_txd)
    );

    int total = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Line monitor: decodes every frame seen on txd by mid-bit sampling.
    int         cyc = 0;
    logic       rst_seen = 1'b1;
    logic       mon_act = 1'b0;
    int         mon_i = 0;
    logic [7:0] mon_b = '0;
    logic [7:0] mon_q [$];
    int         mon_start [$];
    logic [7:0] exp_q [$];

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= reset;
    end

    always @(negedge clk) begin
        if (rst_seen) mon_act = 1'b0;
        else if (!mon_act) begin
            if (uart_txd === 1'b0) begin
                mon_act = 1'b1;
                mon_i = 0;
                mon_start.push_back(cyc);
            end
        end else begin
            mon_i++;
            if (mon_i >= 6 && mon_i <= 34 && mon_i % 4 == 2) mon_b[(mon_i - 6) / 4] = uart_txd;
            if (mon_i == 38) check("tx_stop_bit", {31'b0, uart_txd}, 32'd1);
            if (mon_i == 39) begin
                mon_act = 1'b0;
                mon_q.push_back(mon_b);
            end
        end
    end

    // Receive-side reference state, updated from the register-level rules.
    logic       m_valid = 1'b0;
    logic       m_ovr = 1'b0;
    logic [7:0] m_byte = '0;

    function automatic logic [31:0] m_status();
        return {27'b0, 1'b0, m_ovr, 1'b0, 1'b0, m_valid};
    endfunction

    task automatic model_rx(input logic [7:0] b, input logic stop, input int act);
        logic set_ovr;
        set_ovr = stop && m_valid && act != 1;
        if (stop) begin
            m_valid = 1'b1;
            m_byte  = b;
        end else if (act == 1) m_valid = 1'b0;
        if (set_ovr) m_ovr = 1'b1;
        else if (act == 2) m_ovr = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        MemAddress = a;
        MemWriteData = d;
        MemWrite = 1'b1;
        @(negedge clk);
        MemWrite = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        MemAddress = a;
        MemWrite = 1'b0;
        #1 d = ReadData;
    endtask

    task automatic tx_frame_check(input logic [7:0] b);
        logic [7:0] bb;
        logic       expbit;
        int         j;
        bb = b;
        wr(A_TX, {24'b0, b});
        exp_q.push_back(b);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            MemAddress = A_ST;
            #1;
            j = i / 4;
            if (j == 0) expbit = 1'b0;
            else if (j == 9) expbit = 1'b1;
            else expbit = bb[j - 1];
            check("tx_line_bit", {31'b0, uart_txd}, {31'b0, expbit});
            check("tx_busy_in_frame", {31'b0, ReadData[2]}, 32'd1);
        end
        @(negedge clk);
        MemAddress = A_ST;
        #1;
        check("status_after_frame", ReadData, 32'd0);
        check("txd_idle_after_frame", {31'b0, uart_txd}, 32'd1);
    endtask

    // act: 0 none, 1 RXDATA write on the completion edge, 2 W1C rx_ovr on the completion edge
    task automatic send_rx(input logic [7:0] b, input logic stop, input int act);
        logic [7:0] bb;
        int         j;
        bb = b;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            j = i / 4;
            if (j == 0) rxd_drv = 1'b0;
            else if (j == 9) rxd_drv = stop;
            else rxd_drv = bb[j - 1];
        end
        @(negedge clk);
        rxd_drv = 1'b1;
        if (act != 0) begin
            MemAddress = (act == 1) ? A_RX : A_ST;
            MemWriteData = (act == 2) ? 32'h08 : 32'h0;
            MemWrite = 1'b1;
        end
        @(negedge clk);
        MemWrite = 1'b0;
        model_rx(b, stop, act);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_rx_regs(input string tag);
        logic [31:0] d;
        rd(A_ST, d);
        check({tag, "_status"}, d, m_status());
        rd(A_RX, d);
        check({tag, "_rxdata"}, d, {24'b0, m_byte});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  b;
        int          ns;
        int          w;

        // Reset state and address decode
        repeat (3) @(negedge clk);
        reset = 1'b0;
        rd(A_ST, d);
        check("reset_txd", {31'b0, uart_txd}, 32'd1);
        check("reset_status", d, 32'd0);
        check("reset_hit_base", {31'b0, Hit}, 32'd1);
        rd(A_RES, d);
        check("reserved_read", d, 32'd0);
        rd(A_RX, d);
        check("reset_rxdata", d, 32'd0);
        rd(32'h1000_0008, d);
        check("miss_hit", {31'b0, Hit}, 32'd0);
        check("miss_readdata", d, 32'd0);
        wr(32'h1000_0000, 32'h41);
        wr(A_RES, 32'h18);
        rd(A_ST, d);
        check("miss_write_no_effect", d, 32'd0);

        // Exact TX waveform
        tx_frame_check(8'h55);
        tx_frame_check(8'($urandom_range(0, 255)));

        // FIFO fill, overflow, W1C and back-to-back frames
        ns = mon_start.size();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            b = 8'($urandom_range(0, 255));
            MemAddress = A_TX;
            MemWriteData = {24'b0, b};
            MemWrite = 1'b1;
            if (k < 5) exp_q.push_back(b);
        end
        @(negedge clk);
        MemWrite = 1'b0;
        MemAddress = A_ST;
        #1 check("fifo_full_ovf", ReadData, 32'h16);
        wr(A_ST, 32'h10);
        rd(A_ST, d);
        check("ovf_w1c", d, 32'h06);
        w = 0;
        do begin
            rd(A_ST, d);
            w++;
        end while (d != 32'd0 && w < 600);
        check("tx_drain_in_time", 32'(w < 600), 32'd1);
        repeat (3) @(negedge clk);
        check("frames_sent", 32'(mon_start.size() - ns), 32'd5);
        for (int k = ns + 1; k < mon_start.size(); k++)
            check("frame_gap", 32'(mon_start[k] - mon_start[k - 1]), 32'd40);

        // Loopback
        loop = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            b = (k == 0) ? 8'hA3 : 8'($urandom_range(0, 255));
            wr(A_TX, {24'b0, b});
            exp_q.push_back(b);
            repeat (60) @(negedge clk);
            model_rx(b, 1'b1, 0);
            check_rx_regs("loopback");
            wr(A_RX, 32'h0);
            model_rx(8'h0, 1'b0, 1);
            rd(A_ST, d);
            check("rxdata_write_clears", d, m_status());
        end
        loop = 1'b0;
        repeat (4) @(negedge clk);

        // RX framing error, overrun, same-edge priorities
        send_rx(8'($urandom_range(0, 255)), 1'b0, 0);
        check_rx_regs("framing_err");
        send_rx(8'h11, 1'b1, 0);
        send_rx(8'h22, 1'b1, 0);
        check_rx_regs("overrun");
        send_rx(8'($urandom_range(0, 255)), 1'b1, 2);
        check_rx_regs("ovr_set_beats_w1c");
        wr(A_ST, 32'h08);
        model_rx(8'h0, 1'b0, 2);
        check_rx_regs("ovr_w1c");
        send_rx(8'($urandom_range(0, 255)), 1'b1, 1);
        check_rx_regs("done_beats_clear");

        // Reset mid-frame on both directions
        loop = 1'b1;
        wr(A_TX, {24'b0, 8'($urandom_range(0, 255))});
        repeat (15) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_mid_txd", {31'b0, uart_txd}, 32'd1);
        reset = 1'b0;
        m_valid = 1'b0;
        m_ovr = 1'b0;
        m_byte = 8'h0;
        check_rx_regs("reset_mid");
        repeat (60) @(negedge clk);
        check_rx_regs("reset_no_partial");
        check("reset_txd_stays_high", {31'b0, uart_txd}, 32'd1);

        check("frame_count", 32'(mon_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < mon_q.size(); k++)
            check("frame_byte", {24'b0, mon_q[k]}, {24'b0, exp_q[k]});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
